// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and index type for the register file slice
package rf_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    typedef logic [$clog2(NREG_DEF)-1:0] rf_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, issue handshake and pending count
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR-1:0][AW-1:0]  rd_idx,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rd,
    output logic                    iss_ready,
    output logic [NREG-1:0]         busy,
    output logic [AW:0]             busy_cnt
);
    logic [NREG-1:0] busy_nxt;

    // busy[0] is held at 0, so x0 issues are always accepted
    assign iss_ready = ~busy[iss_rd];

    // clears first, then the accepted reservation, so a same-cycle set wins
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NWR; i++)
            if (wen[i]) busy_nxt[rd_idx[i]] = 1'b0;
        if (iss_valid && iss_ready && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= (AW+1)'($countones(busy_nxt));
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with optional write forwarding and a WAW scoreboard
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [NWR-1:0]           wen,
    input  logic [NWR-1:0][AW-1:0]   rd_idx,
    input  logic [NWR-1:0][XLEN-1:0] rd_wdata,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_rd,
    output logic                     iss_ready,
    input  logic [NRD-1:0][AW-1:0]   rs_idx,
    output logic [NRD-1:0][XLEN-1:0] rs_data,
    output logic [NRD-1:0]           rs_busy,
    output logic [AW:0]              busy_cnt
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    rf_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .wen       (wen),
        .rd_idx    (rd_idx),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // later ports overwrite earlier ones, so the highest-numbered writer wins
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (wen[i] && rd_idx[i] != '0) regs[rd_idx[i]] <= rd_wdata[i];
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [XLEN-1:0] data;
        logic            hit;
        always_comb begin
            data = regs[rs_idx[j]];
            hit  = 1'b0;
            for (int i = 0; i < NWR; i++)
                if (BYPASS && wen[i] && rd_idx[i] == rs_idx[j] && rs_idx[j] != '0) begin
                    data = rd_wdata[i];
                    hit  = 1'b1;
                end
        end
        assign rs_data[j] = ARESETn ? data : '0;
        assign rs_busy[j] = ARESETn & busy[rs_idx[j]] & ~hit;
    end
endmodule
